// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU. It executes the Hack A/C instruction set
// against instruction and data memories that handshake with req/ack and may
// insert wait states on either port.
module hack_cpu_mc #(
   parameter int WIDTH    = 16,
   parameter int AW       = WIDTH - 1,
   parameter int RESET_PC = 0
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   output logic             imem_req_o,
   output logic [AW-1:0]    imem_addr_o,
   input  logic [WIDTH-1:0] imem_rdata_i,
   input  logic             imem_ack_i,
   output logic             dmem_re_o,
   output logic             dmem_we_o,
   output logic [AW-1:0]    dmem_addr_o,
   output logic [WIDTH-1:0] dmem_wdata_o,
   input  logic [WIDTH-1:0] dmem_rdata_i,
   input  logic             dmem_ack_i,
   output logic [AW-1:0]    pc_o,
   output logic             retire_o
);

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_MREAD, S_EXEC, S_MWRITE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, d_q, ir_q, m_q, res_q;
   logic [AW-1:0]    pc_q;
   logic             imem_req_q, dmem_re_q, dmem_we_q, retire_q;

   logic [WIDTH-1:0] alu_x_d, alu_y_d, alu_out_d, result_d;
   logic [AW-1:0]    pc_inc_d, pc_commit_d;
   logic             zr_d, ng_d, taken_d;

   // ALU on the latched instruction; the committed result is the latched RES
   // when committing from MWRITE, otherwise the live ALU output.
   always_comb begin
      alu_x_d = ir_q[11] ? '0 : d_q;
      if (ir_q[10]) alu_x_d = ~alu_x_d;
      alu_y_d = ir_q[12] ? m_q : a_q;
      if (ir_q[9]) alu_y_d = '0;
      if (ir_q[8]) alu_y_d = ~alu_y_d;
      alu_out_d = ir_q[7] ? (alu_x_d + alu_y_d) : (alu_x_d & alu_y_d);
      if (ir_q[6]) alu_out_d = ~alu_out_d;
      result_d    = (state_q == S_MWRITE) ? res_q : alu_out_d;
      zr_d        = (result_d == '0);
      ng_d        = result_d[WIDTH-1];
      taken_d     = (ir_q[2] & ng_d) | (ir_q[1] & zr_d) | (ir_q[0] & ~ng_d & ~zr_d);
      pc_inc_d    = pc_q + AW'(1);
      pc_commit_d = taken_d ? a_q[AW-1:0] : pc_inc_d;
   end

   // Control FSM and architectural state; request strobes are registered and
   // drop on the edge that accepts the ack.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_RST;
         a_q        <= '0;
         d_q        <= '0;
         ir_q       <= '0;
         m_q        <= '0;
         res_q      <= '0;
         pc_q       <= AW'(RESET_PC);
         imem_req_q <= 1'b0;
         dmem_re_q  <= 1'b0;
         dmem_we_q  <= 1'b0;
         retire_q   <= 1'b0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            S_RST: begin
               imem_req_q <= 1'b1;
               state_q    <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack_i) begin
                  ir_q       <= imem_rdata_i;
                  imem_req_q <= 1'b0;
                  // A-type instructions retire in the DECODE cycle
                  retire_q   <= ~imem_rdata_i[WIDTH-1];
                  state_q    <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!ir_q[WIDTH-1]) begin
                  a_q        <= ir_q;
                  pc_q       <= pc_inc_d;
                  imem_req_q <= 1'b1;
                  state_q    <= S_FETCH;
               end else if (ir_q[12]) begin
                  dmem_re_q <= 1'b1;
                  state_q   <= S_MREAD;
               end else begin
                  retire_q <= ~ir_q[3];
                  state_q  <= S_EXEC;
               end
            end
            S_MREAD: begin
               if (dmem_ack_i) begin
                  m_q       <= dmem_rdata_i;
                  dmem_re_q <= 1'b0;
                  retire_q  <= ~ir_q[3];
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (ir_q[3]) begin
                  res_q     <= alu_out_d;
                  dmem_we_q <= 1'b1;
                  state_q   <= S_MWRITE;
               end else begin
                  if (ir_q[5]) a_q <= result_d;
                  if (ir_q[4]) d_q <= result_d;
                  pc_q       <= pc_commit_d;
                  imem_req_q <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            S_MWRITE: begin
               if (dmem_ack_i) begin
                  if (ir_q[5]) a_q <= result_d;
                  if (ir_q[4]) d_q <= result_d;
                  pc_q       <= pc_commit_d;
                  dmem_we_q  <= 1'b0;
                  imem_req_q <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            default: state_q <= S_RST;
         endcase
      end
   end

   // Output map; a store commits in whichever cycle its ack arrives, so that
   // retire term cannot be known a cycle ahead and is decoded from the ack.
   always_comb begin
      imem_req_o   = imem_req_q;
      imem_addr_o  = pc_q;
      dmem_re_o    = dmem_re_q;
      dmem_we_o    = dmem_we_q;
      dmem_addr_o  = a_q[AW-1:0];
      dmem_wdata_o = res_q;
      pc_o         = pc_q;
      retire_o     = retire_q | ((state_q == S_MWRITE) & dmem_ack_i);
   end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb_hack_cpu_mc: memory responders with optional wait states, an ISA-level
// reference model that pre-computes each instruction's bus activity, and a
// monitor that pops and compares an expected record on every retire.
module tb_hack_cpu_mc;
   localparam int W  = 16;
   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          imem_req, imem_ack = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [W-1:0]  imem_rdata = '0;
   logic          dmem_re, dmem_we, dmem_ack = 1'b0;
   logic [AW-1:0] dmem_addr;
   logic [W-1:0]  dmem_wdata, dmem_rdata = '0;
   logic [AW-1:0] pc;
   logic          retire;

   always #5 clk = ~clk;

   hack_cpu_mc #(.WIDTH(W), .AW(AW), .RESET_PC(0)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_rdata_i(imem_rdata), .imem_ack_i(imem_ack),
      .dmem_re_o(dmem_re), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
      .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack),
      .pc_o(pc), .retire_o(retire)
   );

   typedef struct {
      logic [AW-1:0] fetch;
      bit            rd;
      logic [AW-1:0] rd_addr;
      bit            wr;
      logic [AW-1:0] wr_addr;
      logic [W-1:0]  wr_data;
      logic [AW-1:0] next_pc;
      int            cycles;
   } rec_t;

   logic [W-1:0] imem     [0:32767];
   logic [W-1:0] dut_dmem [0:32767];
   logic [W-1:0] ref_dmem [0:32767];
   rec_t exp_q[$];

   int n_cmp = 0, n_err = 0;
   int wait_max = 0, dwait_force = -1;
   bit spurious = 1'b0, lat_chk = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Hack ALU from its definition: zero/negate each input, add or and, negate.
   function automatic logic [W-1:0] hack_alu(logic [W-1:0] x0, logic [W-1:0] y0, logic [5:0] c);
      logic [W-1:0] x, y, o;
      x = c[5] ? '0 : x0;
      if (c[4]) x = ~x;
      y = c[3] ? '0 : y0;
      if (c[2]) y = ~y;
      o = c[1] ? x + y : x & y;
      if (c[0]) o = ~o;
      return o;
   endfunction

   // Instruction-level model: one record per executed instruction.
   task automatic build_model(int n);
      logic [W-1:0]  a, d, ins, y, o, olda;
      logic signed [W-1:0] so;
      logic [AW-1:0] p;
      bit            taken;
      rec_t          r;
      a = '0; d = '0; p = '0;
      for (int i = 0; i < n; i++) begin
         ins = imem[p];
         r.fetch = p; r.rd = 0; r.rd_addr = '0; r.wr = 0; r.wr_addr = '0; r.wr_data = '0;
         if (!ins[15]) begin
            a = ins;
            p = p + 1'b1;
            r.cycles = 2;
         end else begin
            olda = a;
            y = ins[12] ? ref_dmem[olda[AW-1:0]] : olda;
            r.rd = ins[12]; r.rd_addr = olda[AW-1:0];
            o = hack_alu(d, y, ins[11:6]);
            so = o;
            if (ins[3]) begin
               ref_dmem[olda[AW-1:0]] = o;
               r.wr = 1; r.wr_addr = olda[AW-1:0]; r.wr_data = o;
            end
            if (ins[5]) a = o;
            if (ins[4]) d = o;
            taken = (ins[2] && so < 0) || (ins[1] && so == 0) || (ins[0] && so > 0);
            p = taken ? olda[AW-1:0] : p + 1'b1;
            r.cycles = 3 + int'(ins[12]) + int'(ins[3]);
         end
         r.next_pc = p;
         exp_q.push_back(r);
      end
   endtask

   task automatic fill_random(bit with_prog);
      logic [W-1:0] w;
      for (int i = 0; i < 32768; i++) begin
         w = W'($urandom);
         w[15] = ($urandom_range(0, 9) >= 4);
         imem[i] = w;
         dut_dmem[i] = W'($urandom);
      end
      if (with_prog) begin
         imem[0] = 16'h0005; imem[1] = 16'h0007; imem[2] = 16'hEC10; imem[3] = 16'h0064;
         imem[4] = 16'hE308; imem[5] = 16'h0014; imem[6] = 16'hFC10; imem[7] = 16'hE304;
         imem[20] = 16'h0003; imem[21] = 16'hFDE8; imem[22] = 16'h001E; imem[23] = 16'hFC10;
         imem[24] = 16'hE304; imem[25] = 16'h7FFF; imem[26] = 16'hE307; imem[32767] = 16'h0000;
         dut_dmem[20] = 16'hFFFF; dut_dmem[3] = 16'h0009; dut_dmem[30] = 16'h0001;
      end
      for (int i = 0; i < 32768; i++) ref_dmem[i] = dut_dmem[i];
   endtask

   function automatic int pick_wait(bit is_d);
      if (is_d && dwait_force >= 0) return dwait_force;
      return $urandom_range(0, wait_max);
   endfunction

   // Instruction memory responder
   initial begin
      bit act = 0; int wt = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin act = 0; imem_ack = 0; end
         else if (imem_req) begin
            if (!act) begin act = 1; wt = pick_wait(0); end
            if (wt == 0) begin imem_ack = 1; imem_rdata = imem[imem_addr]; act = 0; end
            else begin wt--; imem_ack = 0; imem_rdata = W'($urandom); end
         end else begin
            imem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = W'($urandom);
         end
      end
   end

   // Data memory responder
   initial begin
      bit act = 0; int wt = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin act = 0; dmem_ack = 0; end
         else if (dmem_re || dmem_we) begin
            if (!act) begin act = 1; wt = pick_wait(1); end
            if (wt == 0) begin
               if (dmem_we) dut_dmem[dmem_addr] = dmem_wdata;
               dmem_rdata = dut_dmem[dmem_addr];
               dmem_ack = 1; act = 0;
            end else begin wt--; dmem_ack = 0; dmem_rdata = W'($urandom); end
         end else begin
            dmem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            dmem_rdata = W'($urandom);
         end
      end
   end

   // Monitor: observe accepted transfers, compare against the queue on retire
   initial begin
      logic [AW-1:0] obs_fetch, obs_rd_addr, obs_wr_addr, pc_exp, d_addr0;
      logic [W-1:0]  obs_wr_data, d_wd0;
      bit obs_rd, obs_wr, pc_pend;
      int cyc, d_hold;
      rec_t r;
      obs_fetch = 'x; obs_rd = 0; obs_wr = 0; pc_pend = 0; cyc = 0; d_hold = 0;
      obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0; pc_exp = '0; d_addr0 = '0; d_wd0 = '0;
      forever begin
         @(negedge clk); #1;
         if (!reset_n) begin
            obs_fetch = 'x; obs_rd = 0; obs_wr = 0; pc_pend = 0; cyc = 0; d_hold = 0;
         end else begin
            cyc++;
            if (pc_pend) begin check("pc_after_commit", 32'(pc), 32'(pc_exp)); pc_pend = 0; end
            if (dmem_re || dmem_we) begin
               check("re_we_exclusive", 32'(dmem_re & dmem_we), 32'd0);
               if (d_hold == 0) begin d_addr0 = dmem_addr; d_wd0 = dmem_wdata; end
               else begin
                  check("dmem_addr_stable", 32'(dmem_addr), 32'(d_addr0));
                  if (dmem_we) check("dmem_wdata_stable", 32'(dmem_wdata), 32'(d_wd0));
               end
               d_hold++;
            end else d_hold = 0;
            if (imem_req && imem_ack) obs_fetch = imem_addr;
            if (dmem_re && dmem_ack) begin obs_rd = 1; obs_rd_addr = dmem_addr; end
            if (dmem_we && dmem_ack) begin obs_wr = 1; obs_wr_addr = dmem_addr; obs_wr_data = dmem_wdata; end
            if (retire) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL retire_unexpected: got retire expected none at %0t", $time);
               end else begin
                  r = exp_q.pop_front();
                  check("fetch_addr", 32'(obs_fetch), 32'(r.fetch));
                  check("read_flag", 32'(obs_rd), 32'(r.rd));
                  if (r.rd && obs_rd) check("read_addr", 32'(obs_rd_addr), 32'(r.rd_addr));
                  check("write_flag", 32'(obs_wr), 32'(r.wr));
                  if (r.wr && obs_wr) begin
                     check("write_addr", 32'(obs_wr_addr), 32'(r.wr_addr));
                     check("write_data", 32'(obs_wr_data), 32'(r.wr_data));
                  end
                  if (lat_chk) check("latency", 32'(cyc), 32'(r.cycles));
                  pc_pend = 1; pc_exp = r.next_pc;
               end
               obs_fetch = 'x; obs_rd = 0; obs_wr = 0; cyc = 0;
            end
         end
      end
   end

   // Reset, check reset outputs, release, then run until n records retired
   task automatic reset_and_run(int n);
      bit done;
      reset_n = 0;
      exp_q.delete();
      build_model(n + 8);
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dmem_re_we", 32'({dmem_re, dmem_we}), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      check("rst_wdata", 32'(dmem_wdata), 32'd0);
      #1 reset_n = 1;
      @(posedge clk); #1;
      check("first_fetch_req", 32'(imem_req), 32'd1);
      check("first_fetch_addr", 32'(imem_addr), 32'd0);
      done = 0;
      for (int c = 0; c < 20000 && !done; c++) begin
         @(negedge clk); #3;
         if (exp_q.size() <= 8) done = 1;
      end
      check("phase_drained", 32'(done), 32'd1);
      reset_n = 0;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      // directed program, zero-wait, latency checked
      wait_max = 0; spurious = 0; dwait_force = -1; lat_chk = 1;
      fill_random(1);
      reset_and_run(40);
      // random program, zero-wait, latency checked
      fill_random(0);
      reset_and_run(300);
      // random program, random wait states and stray acks
      wait_max = 3; spurious = 1; lat_chk = 0;
      fill_random(0);
      reset_and_run(400);
      // reset asserted while a store waits for its ack
      wait_max = 0; spurious = 0; dwait_force = 60;
      fill_random(1);
      exp_q.delete();
      build_model(10);
      repeat (3) @(posedge clk);
      @(negedge clk); #3 reset_n = 1;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk); #1;
         if (dmem_we) seen = 1;
      end
      check("mwrite_seen", 32'(seen), 32'd1);
      repeat (3) begin
         @(negedge clk); #1;
         check("mwrite_held_we", 32'(dmem_we), 32'd1);
         check("mwrite_addr", 32'(dmem_addr), 32'd100);
         check("mwrite_wdata", 32'(dmem_wdata), 32'd7);
      end
      #1 reset_n = 0;
      #1;
      check("async_rst_we", 32'(dmem_we), 32'd0);
      check("async_rst_pc", 32'(pc), 32'd0);
      check("async_rst_imem_req", 32'(imem_req), 32'd0);
      exp_q.delete();
      dwait_force = -1;
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
